// File: rtl/ysyx_040729_pkg.sv
// Shared CLINT definitions: register offsets, FSM encoding and the offset decoder.
// Latency: none (package only).
// Backpressure: not applicable.
package ysyx_040729_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } clint_state_e;

    typedef enum logic [1:0] {
        SEL_NONE     = 2'd0,
        SEL_MSIP     = 2'd1,
        SEL_MTIMECMP = 2'd2,
        SEL_MTIME    = 2'd3
    } clint_sel_e;

    // Exact-match decode; any other offset is unmapped.
    function automatic clint_sel_e clint_decode(input logic [15:0] addr);
        clint_sel_e sel;
        case (addr)
            CLINT_MSIP_OFF:     sel = SEL_MSIP;
            CLINT_MTIMECMP_OFF: sel = SEL_MTIMECMP;
            CLINT_MTIME_OFF:    sel = SEL_MTIME;
            default:            sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ysyx_040729_clint_tick.sv
// mtime prescaler: emits a one-cycle tick every TICK_DIV cycles.
// Latency: tick is a registered-count compare, valid in the cycle the count hits TICK_DIV-1.
// Backpressure: none; clr_i restarts the count at 0 on the next edge.
module ysyx_040729_clint_tick #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned    CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Next count: clear wins, otherwise wrap at TICK_DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_040729_clint.sv
// Core-local interruptor: msip / mtimecmp / mtime registers behind a valid-ready bus; msip optional via YSYX_040729_CLINT_MSIP_EN.
// Latency: request accepted in IDLE, response valid from the next cycle; write/read-sample happen in the handshake cycle.
// Backpressure: response held stable until resp_ready; req_ready low while a response is outstanding.
module ysyx_040729_clint
    import ysyx_040729_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TICK_DIV   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [15:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    tirp_o,
    output logic                    sirp_o
);

    localparam int BW = DATA_WIDTH / 8;

    clint_state_e          state_q, state_d;
    clint_sel_e            sel;
    logic [DATA_WIDTH-1:0] mtime_q, mtime_d;
    logic [DATA_WIDTH-1:0] mtimecmp_q, mtimecmp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  tirp_q;
    logic                  hs, wr, mtime_wr, tick;
    logic                  msip_rd;

    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [BW-1:0]         mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < BW; b++) begin
            if (mask[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign tirp_o     = tirp_q;

    assign hs       = req_valid & req_ready;
    assign sel      = clint_decode(req_addr);
    assign wr       = hs & req_wen;
    assign mtime_wr = wr & (sel == SEL_MTIME);

    // A bus write to mtime restarts the prescaler so the next tick is a full period away.
    ysyx_040729_clint_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (mtime_wr),
        .tick_o (tick)
    );

`ifdef YSYX_040729_CLINT_MSIP_EN
    logic msip_q;

    // msip holds only bit 0; it is written when byte 0 is enabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msip_q <= 1'b0;
        end else if (wr && (sel == SEL_MSIP) && req_wmask[0]) begin
            msip_q <= req_wdata[0];
        end
    end

    assign msip_rd = msip_q;
    assign sirp_o  = msip_q;
`else
    assign msip_rd = 1'b0;
    assign sirp_o  = 1'b0;
`endif

    // Timer registers: bus write beats a same-cycle tick.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (mtime_wr) begin
            mtime_d = byte_merge(mtime_q, req_wdata, req_wmask);
        end else if (tick) begin
            mtime_d = mtime_q + DATA_WIDTH'(1);
        end
        if (wr && (sel == SEL_MTIMECMP)) begin
            mtimecmp_d = byte_merge(mtimecmp_q, req_wdata, req_wmask);
        end
    end

    // Bus FSM: latch the response at handshake, hold it until the requester takes it.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_RESP;
                    err_d   = (sel == SEL_NONE);
                    rdata_d = '0;
                    if (!req_wen) begin
                        case (sel)
                            SEL_MSIP:     rdata_d = {{(DATA_WIDTH-1){1'b0}}, msip_rd};
                            SEL_MTIMECMP: rdata_d = mtimecmp_q;
                            SEL_MTIME:    rdata_d = mtime_q;
                            default:      rdata_d = '0;
                        endcase
                    end
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, timer and registered interrupt compare.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tirp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            tirp_q     <= (mtime_q >= mtimecmp_q);
        end
    end

endmodule

// File: tb/tb_ysyx_040729_clint.sv
// Self-checking bench for ysyx_040729_clint: table of bus transactions plus timed sequences.
// Latency: two cycles per transaction when the response is taken immediately.
// Backpressure: one sequence stalls resp_ready to exercise response hold.
module tb_ysyx_040729_clint;

    localparam logic [15:0] A_MSIP = 16'h0000;
    localparam logic [15:0] A_CMP  = 16'h4000;
    localparam logic [15:0] A_TIME = 16'hBFF8;

`ifdef YSYX_040729_CLINT_MSIP_EN
    localparam logic MSIP_ON = 1'b1;
`else
    localparam logic MSIP_ON = 1'b0;
`endif

    logic        clock, reset;
    logic        req_valid, req_wen, resp_ready;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;

    logic        req_ready, resp_valid, resp_err, tirp_o, sirp_o;
    logic [63:0] resp_rdata;
    logic        d3_req_ready, d3_resp_valid, d3_resp_err, d3_tirp_o, d3_sirp_o;
    logic [63:0] d3_resp_rdata;

    int total = 0;
    int bad   = 0;

    ysyx_040729_clint #(.DATA_WIDTH(64), .TICK_DIV(1)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .tirp_o     (tirp_o),
        .sirp_o     (sirp_o)
    );

    // Second instance with a slower prescaler, driven by the same bus.
    ysyx_040729_clint #(.DATA_WIDTH(64), .TICK_DIV(3)) u_dut3 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (d3_req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (d3_resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (d3_resp_rdata),
        .resp_err   (d3_resp_err),
        .tirp_o     (d3_tirp_o),
        .sirp_o     (d3_sirp_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wen;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic        exp_sirp;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the handshake.
    task automatic req_send(input logic wen, input logic [15:0] addr,
                            input logic [63:0] wd, input logic [7:0] wm);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready_wait", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = wm;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic resp_take(output logic [63:0] rd, output logic er, output logic [63:0] rd3);
        int n;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("resp_valid_wait", {63'b0, resp_valid}, 64'd1);
        rd  = resp_rdata;
        er  = resp_err;
        rd3 = d3_resp_rdata;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic txn(input logic wen, input logic [15:0] addr, input logic [63:0] wd,
                       input logic [7:0] wm, output logic [63:0] rd, output logic er,
                       output logic [63:0] rd3);
        req_send(wen, addr, wd, wm);
        resp_take(rd, er, rd3);
    endtask

    initial begin
        logic [63:0] rd, rd3;
        logic        er;

        tbl[0]  = '{1'b1, A_CMP,   64'h1122_3344_5566_7788, 8'hFF, 64'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, A_CMP,   64'h0,                   8'h00, 64'h1122_3344_5566_7788, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, A_CMP,   64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, A_CMP,   64'h0,                   8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, A_CMP,   64'h00FF_0000_0000_0000, 8'h40, 64'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, A_CMP,   64'h0,                   8'h00, 64'h11FF_3344_AAAA_AAAA, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h4004, 64'h0,                  8'hFF, 64'h0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, A_CMP,   64'h0,                   8'h00, 64'h11FF_3344_AAAA_AAAA, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 16'hBFF0, 64'h0,                  8'h00, 64'h0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, A_MSIP,  64'h1,                   8'h01, 64'h0, 1'b0, MSIP_ON};
        tbl[10] = '{1'b0, A_MSIP,  64'h0,                   8'h00, {63'b0, MSIP_ON}, 1'b0, MSIP_ON};
        tbl[11] = '{1'b1, A_MSIP,  64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'h0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, A_MSIP,  64'h1,                   8'hFE, 64'h0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, A_MSIP,  64'hFF,                  8'h01, 64'h0, 1'b0, MSIP_ON};
        tbl[14] = '{1'b0, A_MSIP,  64'h0,                   8'h00, {63'b0, MSIP_ON}, 1'b0, MSIP_ON};
        tbl[15] = '{1'b1, A_MSIP,  64'h0,                   8'h01, 64'h0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 16'h0008, 64'h0,                  8'h00, 64'h0, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 16'hBFFC, 64'h0,                  8'h00, 64'h0, 1'b1, 1'b0};

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        resp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err",   {63'b0, resp_err}, 64'd0);
        chk("rst_tirp",       {63'b0, tirp_o}, 64'd0);
        chk("rst_sirp",       {63'b0, sirp_o}, 64'd0);
        reset = 1'b1;
        #1;
        chk("rel_req_ready",  {63'b0, req_ready}, 64'd1);

        // Ten idle cycles, then read mtime
        repeat (10) @(negedge clock);
        txn(1'b0, A_TIME, 64'h0, 8'h00, rd, er, rd3);
        chk("idle_mtime",     rd, 64'd10);
        chk("idle_mtime_err", {63'b0, er}, 64'd0);
        chk("idle_mtime_div3", rd3, 64'd3);
        chk("idle_tirp",      {63'b0, tirp_o}, 64'd0);

        // Directed table
        for (int i = 0; i < 18; i++) begin
            txn(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, rd, er, rd3);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), {63'b0, er}, {63'b0, tbl[i].exp_err});
            chk($sformatf("tbl%0d_sirp", i), {63'b0, sirp_o}, {63'b0, tbl[i].exp_sirp});
        end

        // tirp rises one cycle after mtime reaches mtimecmp
        txn(1'b1, A_CMP, 64'h20, 8'hFF, rd, er, rd3);
        txn(1'b1, A_TIME, 64'h10, 8'hFF, rd, er, rd3);
        chk("wr_mtime_rdata", rd, 64'd0);
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("tirp_rise_k%0d", k), {63'b0, tirp_o}, (k >= 17) ? 64'd1 : 64'd0);
            @(negedge clock);
        end
        req_send(1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        chk("tirp_hold",  {63'b0, tirp_o}, 64'd1);
        resp_take(rd, er, rd3);
        chk("tirp_fall",  {63'b0, tirp_o}, 64'd0);

        // mtime wraps all-ones to zero
        txn(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er, rd3);
        chk("wrap_tirp_fe", {63'b0, tirp_o}, 64'd0);
        @(negedge clock);
        chk("wrap_tirp_ff", {63'b0, tirp_o}, 64'd1);
        req_send(1'b0, A_TIME, 64'h0, 8'h00);
        chk("wrap_tirp_00", {63'b0, tirp_o}, 64'd0);
        resp_take(rd, er, rd3);
        chk("wrap_mtime",      rd,  64'd0);
        chk("wrap_mtime_div3", rd3, 64'hFFFF_FFFF_FFFF_FFFE);

        // Masked mtime write in a tick cycle: tick dropped, upper bytes kept
        txn(1'b1, A_TIME, 64'hAABB_CCDD_EEFF_1122, 8'hFF, rd, er, rd3);
        txn(1'b1, A_TIME, 64'h100, 8'h01, rd, er, rd3);
        txn(1'b0, A_TIME, 64'h0, 8'h00, rd, er, rd3);
        chk("mask_mtime",      rd,  64'hAABB_CCDD_EEFF_1101);
        chk("mask_mtime_div3", rd3, 64'hAABB_CCDD_EEFF_1100);

        // Unmapped read with a stalled response; a competing write must not be taken
        req_send(1'b0, 16'h1234, 64'h0, 8'h00);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = A_CMP;
        req_wdata = 64'h0;
        req_wmask = 8'hFF;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("stall%0d_valid", s), {63'b0, resp_valid}, 64'd1);
            chk($sformatf("stall%0d_err", s),   {63'b0, resp_err}, 64'd1);
            chk($sformatf("stall%0d_rdata", s), resp_rdata, 64'd0);
            chk($sformatf("stall%0d_ready", s), {63'b0, req_ready}, 64'd0);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        chk("stall_done_valid", {63'b0, resp_valid}, 64'd0);
        txn(1'b0, A_CMP, 64'h0, 8'h00, rd, er, rd3);
        chk("stall_cmp_kept", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        // msip drives sirp_o the cycle after the write
        req_send(1'b1, A_MSIP, 64'h1, 8'h01);
        chk("msip_sirp_next", {63'b0, sirp_o}, {63'b0, MSIP_ON});
        resp_take(rd, er, rd3);
        txn(1'b0, A_MSIP, 64'h0, 8'h00, rd, er, rd3);
        chk("msip_read",     rd, {63'b0, MSIP_ON});
        chk("msip_read_err", {63'b0, er}, 64'd0);
        txn(1'b1, A_MSIP, 64'h0, 8'h01, rd, er, rd3);
        chk("msip_clear",    {63'b0, sirp_o}, 64'd0);

        // Reset in the middle of a transaction
        txn(1'b1, A_CMP, 64'h55, 8'hFF, rd, er, rd3);
        req_send(1'b0, A_CMP, 64'h0, 8'h00);
        chk("mid_pre_valid", {63'b0, resp_valid}, 64'd1);
        chk("mid_pre_tirp",  {63'b0, tirp_o}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {63'b0, resp_valid}, 64'd0);
        chk("mid_rst_rdata", resp_rdata, 64'd0);
        chk("mid_rst_tirp",  {63'b0, tirp_o}, 64'd0);
        chk("mid_rst_ready", {63'b0, req_ready}, 64'd1);
        @(negedge clock);
        reset = 1'b1;
        txn(1'b0, A_TIME, 64'h0, 8'h00, rd, er, rd3);
        chk("post_rst_mtime",    rd,  64'd0);
        chk("post_rst_mtime_d3", rd3, 64'd0);
        txn(1'b0, A_CMP, 64'h0, 8'h00, rd, er, rd3);
        chk("post_rst_cmp",      rd,  64'hFFFF_FFFF_FFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
